// File: rtl/ps2_pkg.sv
// PS/2 shared types: FSM state encoding, frame geometry and default cycle constants for ps2_tx / ps2_rx.
// Latency: n/a (package). Backpressure: n/a.
// Default constants assume the 25 MHz divided clock.
package ps2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RTS   = 3'd1,
        ST_START = 3'd2,
        ST_DATA  = 3'd3,
        ST_STOP  = 3'd4,
        ST_WAIT  = 3'd5
    } ps2_state_t;

    localparam int FRAME_BITS          = 11;
    localparam int DATA_BITS           = 8;
    localparam int INHIBIT_CYCLES_DFLT = 2500;
    localparam int FILTER_LEN_DFLT     = 8;
    localparam int TIMEOUT_CYCLES_DFLT = 500000;

    // PS/2 uses odd parity over the data byte
    function automatic logic odd_parity(input logic [DATA_BITS-1:0] b);
        return ~^b;
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Glitch filter for one PS/2 line: level changes only after FILTER_LEN equal samples; fall pulses on 1->0.
// Latency: FILTER_LEN+1 clk from pad change to level/fall. Backpressure: none, free-running.
// Reset level is high (idle bus), so a line held low through reset produces one fall afterwards.
module ps2_line_filter
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN = FILTER_LEN_DFLT
) (
    input  logic clk,
    input  logic reset,
    input  logic line_in,
    output logic level,
    output logic fall
);

    logic [FILTER_LEN-1:0] samples;

    always_ff @(posedge clk) begin
        if (reset) begin
            samples <= '1;
            level   <= 1'b1;
            fall    <= 1'b0;
        end else begin
            samples <= {samples[FILTER_LEN-2:0], line_in};
            fall    <= 1'b0;
            if (&samples) begin
                level <= 1'b1;
            end else if (~|samples) begin
                level <= 1'b0;
                fall  <= level;
            end
        end
    end

endmodule

// File: rtl/ps2_tx.sv
// Host-to-device PS/2 transmitter: request-to-send, 11-bit frame clocked by the device, ack check.
// Latency: tx_idle drops 1 clk after wr_ps2; ps2c held low INHIBIT_CYCLES; frame paced by device clock.
// Backpressure: wr_ps2 accepted only while tx_idle=1, otherwise dropped. Watchdog via PS2_TX_TIMEOUT_EN.
module ps2_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = INHIBIT_CYCLES_DFLT,
    parameter int FILTER_LEN     = FILTER_LEN_DFLT
`ifdef PS2_TX_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DFLT
`endif
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 wr_ps2,
    input  logic [DATA_BITS-1:0] din,
    input  logic                 ps2c_in,
    input  logic                 ps2d_in,
    output logic                 ps2c_oe,
    output logic                 ps2d_oe,
    output logic                 tx_idle,
    output logic                 tx_done,
    output logic                 tx_err
);

    // One counter serves both the RTS inhibit and, when enabled, the watchdog
`ifdef PS2_TX_TIMEOUT_EN
    localparam int CNT_MAX = (TIMEOUT_CYCLES > INHIBIT_CYCLES) ? TIMEOUT_CYCLES : INHIBIT_CYCLES;
`else
    localparam int CNT_MAX = INHIBIT_CYCLES;
`endif
    localparam int CNT_W = $clog2(CNT_MAX + 1);
    localparam logic [3:0] BIT_LAST = 4'(FRAME_BITS - 2);

    ps2_state_t           state, state_n;
    logic [DATA_BITS:0]   shift, shift_n;
    logic [3:0]           bit_cnt, bit_cnt_n;
    logic [CNT_W-1:0]     cnt, cnt_n;
    logic                 ack_ok, ack_ok_n;
    logic                 c_oe_n, d_oe_n, done_n, err_n;
    logic                 c_lvl, c_fall, d_lvl, d_fall_unused;

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_c (
        .clk     (clk),
        .reset   (reset),
        .line_in (ps2c_in),
        .level   (c_lvl),
        .fall    (c_fall)
    );

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_d (
        .clk     (clk),
        .reset   (reset),
        .line_in (ps2d_in),
        .level   (d_lvl),
        .fall    (d_fall_unused)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            shift   <= '0;
            bit_cnt <= '0;
            cnt     <= '0;
            ack_ok  <= 1'b0;
            ps2c_oe <= 1'b0;
            ps2d_oe <= 1'b0;
            tx_done <= 1'b0;
            tx_err  <= 1'b0;
        end else begin
            state   <= state_n;
            shift   <= shift_n;
            bit_cnt <= bit_cnt_n;
            cnt     <= cnt_n;
            ack_ok  <= ack_ok_n;
            ps2c_oe <= c_oe_n;
            ps2d_oe <= d_oe_n;
            tx_done <= done_n;
            tx_err  <= err_n;
        end
    end

    always_comb begin
        state_n   = state;
        shift_n   = shift;
        bit_cnt_n = bit_cnt;
        cnt_n     = cnt;
        ack_ok_n  = ack_ok;
        c_oe_n    = ps2c_oe;
        d_oe_n    = ps2d_oe;
        done_n    = 1'b0;
        err_n     = 1'b0;

        case (state)
            ST_IDLE: begin
                c_oe_n = 1'b0;
                d_oe_n = 1'b0;
                if (wr_ps2) begin
                    shift_n   = {odd_parity(din), din};
                    bit_cnt_n = '0;
                    cnt_n     = '0;
                    c_oe_n    = 1'b1;
                    state_n   = ST_RTS;
                end
            end
            ST_RTS: begin
                if (cnt == CNT_W'(INHIBIT_CYCLES - 1)) begin
                    // start bit goes out as the clock is released
                    c_oe_n  = 1'b0;
                    d_oe_n  = 1'b1;
                    cnt_n   = '0;
                    state_n = ST_START;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            ST_START: begin
                if (c_fall) begin
                    d_oe_n    = ~shift[0];
                    shift_n   = {1'b0, shift[DATA_BITS:1]};
                    bit_cnt_n = 4'd1;
                    state_n   = ST_DATA;
                end
            end
            ST_DATA: begin
                if (c_fall) begin
                    if (bit_cnt == BIT_LAST) begin
                        d_oe_n  = 1'b0;
                        state_n = ST_STOP;
                    end else begin
                        d_oe_n    = ~shift[0];
                        shift_n   = {1'b0, shift[DATA_BITS:1]};
                        bit_cnt_n = bit_cnt + 4'd1;
                    end
                end
            end
            ST_STOP: begin
                d_oe_n = 1'b0;
                if (c_fall) begin
                    ack_ok_n = ~d_lvl;
                    state_n  = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (c_lvl && d_lvl) begin
                    done_n  = ack_ok;
                    err_n   = ~ack_ok;
                    state_n = ST_IDLE;
                end
            end
            default: begin
                c_oe_n  = 1'b0;
                d_oe_n  = 1'b0;
                state_n = ST_IDLE;
            end
        endcase

`ifdef PS2_TX_TIMEOUT_EN
        if (state != ST_IDLE && state != ST_RTS) begin
            cnt_n = c_fall ? '0 : cnt + 1'b1;
        end
        if (state != ST_IDLE && cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            c_oe_n  = 1'b0;
            d_oe_n  = 1'b0;
            done_n  = 1'b0;
            err_n   = 1'b1;
            state_n = ST_IDLE;
        end
`endif
    end

    assign tx_idle = (state == ST_IDLE);

endmodule

// File: tb/tb_ps2_tx.sv
// Bench for ps2_tx: keyboard model clocking frames on a wired-AND bus, checking bits, parity, ack handling.
// Device half-period is scaled down to HALF clk cycles to keep runs short.
module tb_ps2_tx;

    localparam int HALF = 50;
    localparam int INH  = 2500;
    localparam int TO   = 5000;

    logic       clk = 1'b0;
    logic       reset;
    logic       wr_ps2;
    logic [7:0] din;
    logic       ps2c_oe, ps2d_oe, tx_idle, tx_done, tx_err;
    logic       dev_c, dev_d;
    logic       ps2c_pad, ps2d_pad;

    int checks = 0;
    int failures = 0;
    int done_cnt = 0, err_cnt = 0, both_cnt = 0;
    int rts_run = 0, last_rts = 0;

    always #5 clk = ~clk;

    assign ps2c_pad = ~(ps2c_oe | dev_c);
    assign ps2d_pad = ~(ps2d_oe | dev_d);

    ps2_tx #(
        .INHIBIT_CYCLES (INH),
        .FILTER_LEN     (8)
`ifdef PS2_TX_TIMEOUT_EN
        ,
        .TIMEOUT_CYCLES (TO)
`endif
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .wr_ps2  (wr_ps2),
        .din     (din),
        .ps2c_in (ps2c_pad),
        .ps2d_in (ps2d_pad),
        .ps2c_oe (ps2c_oe),
        .ps2d_oe (ps2d_oe),
        .tx_idle (tx_idle),
        .tx_done (tx_done),
        .tx_err  (tx_err)
    );

    // Pulse and RTS-width bookkeeping, sampled just after each active edge
    always @(posedge clk) begin
        #1;
        if (tx_done) done_cnt++;
        if (tx_err) err_cnt++;
        if (tx_done && tx_err) both_cnt++;
        if (ps2c_oe) rts_run++;
        else if (rts_run > 0) begin
            last_rts = rts_run;
            rts_run = 0;
        end
    end

    function automatic logic exp_parity(input logic [7:0] b);
        return ($countones(b) % 2 == 0) ? 1'b1 : 1'b0;
    endfunction

    task automatic send_cmd(input logic [7:0] b);
        @(negedge clk);
        wr_ps2 = 1'b1;
        din = b;
        @(negedge clk);
        wr_ps2 = 1'b0;
        din = 8'($urandom);
        checks++;
        if (tx_idle !== 1'b0) begin
            failures++;
            $display("FAIL idle_fall got=%0b want=0", tx_idle);
        end
    endtask

    task automatic wait_start(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < INH + 1000; i++) begin
            @(negedge clk);
            if (ps2c_pad && !ps2d_pad && !ps2c_oe) begin
                ok = 1'b1;
                break;
            end
        end
        if (ok) repeat (20) @(negedge clk);
    endtask

    task automatic dev_pulse(output logic sampled);
        dev_c = 1'b1;
        repeat (HALF) @(negedge clk);
        dev_c = 1'b0;
        @(negedge clk);
        sampled = ps2d_pad;
        repeat (HALF - 1) @(negedge clk);
    endtask

    // Keyboard side: 10 clocks sampling d0..d7, parity, stop, then an 11th clock for the ack
    task automatic dev_receive(input bit do_ack, output logic [7:0] data, output logic par,
                               output logic stop, output bit ok);
        logic [9:0] bits;
        logic s;
        bits = '0;
        data = '0;
        par = 1'b0;
        stop = 1'b0;
        wait_start(ok);
        if (!ok) return;
        for (int b = 0; b < 10; b++) begin
            dev_pulse(s);
            bits[b] = s;
        end
        data = bits[7:0];
        par = bits[8];
        stop = bits[9];
        if (do_ack) dev_d = 1'b1;
        dev_pulse(s);
        dev_d = 1'b0;
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (tx_idle) begin
                ok = 1'b1;
                break;
            end
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic run_frame(input logic [7:0] b, input bit ack, input string tag);
        int d0, e0;
        logic [7:0] data;
        logic par, stop;
        bit ok;
        d0 = done_cnt;
        e0 = err_cnt;
        send_cmd(b);
        dev_receive(ack, data, par, stop, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s_start got=no_start want=start_bit", tag);
            return;
        end
        checks++;
        if (data !== b) begin failures++; $display("FAIL %s_data got=%0h want=%0h", tag, data, b); end
        checks++;
        if (par !== exp_parity(b)) begin
            failures++; $display("FAIL %s_parity got=%0b want=%0b", tag, par, exp_parity(b));
        end
        checks++;
        if (stop !== 1'b1) begin failures++; $display("FAIL %s_stop got=%0b want=1", tag, stop); end
        wait_idle(ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL %s_idle got=busy want=idle", tag); end
        checks++;
        if ((done_cnt - d0) !== (ack ? 1 : 0) || (err_cnt - e0) !== (ack ? 0 : 1)) begin
            failures++;
            $display("FAIL %s_result got=done%0d/err%0d want=done%0d/err%0d", tag,
                     done_cnt - d0, err_cnt - e0, ack ? 1 : 0, ack ? 0 : 1);
        end
        checks++;
        if (ps2c_oe !== 1'b0 || ps2d_oe !== 1'b0) begin
            failures++; $display("FAIL %s_release got=%0b%0b want=00", tag, ps2c_oe, ps2d_oe);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; wr_ps2 = 1'b0; din = '0; dev_c = 1'b0; dev_d = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({ps2c_oe, ps2d_oe, tx_idle, tx_done, tx_err} !== 5'b00100) begin
            failures++;
            $display("FAIL reset_outs got=%05b want=00100", {ps2c_oe, ps2d_oe, tx_idle, tx_done, tx_err});
        end
        reset = 1'b0;
        repeat (20) @(negedge clk);
    endtask

    task automatic test_basic();
        run_frame(8'hED, 1'b1, "basic_ed");
        checks++;
        if (last_rts !== INH) begin failures++; $display("FAIL rts_width got=%0d want=%0d", last_rts, INH); end
    endtask

    task automatic test_parity();
        run_frame(8'h01, 1'b1, "par_01");
        run_frame(8'hFF, 1'b1, "par_ff");
        run_frame(8'h00, 1'b1, "par_00");
    endtask

    task automatic test_no_ack();
        run_frame(8'hF4, 1'b0, "noack");
    endtask

    task automatic test_reset_mid();
        int d0, e0;
        bit ok;
        logic s;
        send_cmd(8'h3C);
        wait_start(ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL rstmid_start got=no_start want=start_bit"); end
        for (int i = 0; i < 4; i++) dev_pulse(s);
        dev_c = 1'b1;
        repeat (20) @(negedge clk);
        d0 = done_cnt;
        e0 = err_cnt;
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if ({ps2c_oe, ps2d_oe, tx_idle} !== 3'b001) begin
            failures++; $display("FAIL rstmid_outs got=%03b want=001", {ps2c_oe, ps2d_oe, tx_idle});
        end
        reset = 1'b0;
        dev_c = 1'b0;
        repeat (30) @(negedge clk);
        checks++;
        if (done_cnt !== d0 || err_cnt !== e0) begin
            failures++; $display("FAIL rstmid_pulses got=%0d want=0", (done_cnt - d0) + (err_cnt - e0));
        end
        run_frame(8'hF4, 1'b1, "after_rst");
    endtask

    task automatic test_ignore_wr();
        int d0, busy;
        logic [7:0] data;
        logic par, stop;
        bit ok, ok2;
        d0 = done_cnt;
        send_cmd(8'hF4);
        fork
            dev_receive(1'b1, data, par, stop, ok);
            begin
                repeat (1000) @(negedge clk);
                wr_ps2 = 1'b1; din = 8'hAA;
                @(negedge clk);
                wr_ps2 = 1'b0;
                repeat (2000) @(negedge clk);
                wr_ps2 = 1'b1; din = 8'hAA;
                @(negedge clk);
                wr_ps2 = 1'b0;
            end
        join
        checks++;
        if (!ok || data !== 8'hF4) begin failures++; $display("FAIL ignore_data got=%0h want=f4", data); end
        wait_idle(ok2);
        checks++;
        if (!ok2 || done_cnt - d0 !== 1) begin
            failures++; $display("FAIL ignore_done got=%0d want=1", done_cnt - d0);
        end
        busy = 0;
        repeat (3000) begin
            @(negedge clk);
            if (!tx_idle) busy++;
        end
        checks++;
        if (busy !== 0) begin failures++; $display("FAIL ignore_nostart got=%0d want=0", busy); end
    endtask

    task automatic test_random();
        logic [7:0] b;
        bit ack;
        for (int i = 0; i < 5; i++) begin
            b = 8'($urandom);
            ack = ($urandom_range(0, 3) != 0);
            run_frame(b, ack, $sformatf("rnd%0d", i));
        end
    endtask

    task automatic test_silent();
        bit ok;
        int e0, n;
        e0 = err_cnt;
        send_cmd(8'h55);
        wait_start(ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL silent_start got=no_start want=start_bit"); end
`ifdef PS2_TX_TIMEOUT_EN
        n = 20;
        while (err_cnt == e0 && n < TO + 2000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n < TO - 5 || n > TO + 5) begin failures++; $display("FAIL timeout_at got=%0d want=%0d", n, TO); end
        @(negedge clk);
        checks++;
        if ({ps2c_oe, ps2d_oe, tx_idle, err_cnt - e0} !== {3'b001, 32'd1}) begin
            failures++; $display("FAIL timeout_state got=%0b%0b%0b err%0d want=001 err1",
                                 ps2c_oe, ps2d_oe, tx_idle, err_cnt - e0);
        end
`else
        n = 0;
        repeat (10000) begin
            @(negedge clk);
            if (tx_idle) n++;
        end
        checks++;
        if (n !== 0 || ps2d_oe !== 1'b1 || ps2c_oe !== 1'b0 || err_cnt !== e0) begin
            failures++; $display("FAIL silent_hold got=idle%0d c%0b d%0b want=idle0 c0 d1", n, ps2c_oe, ps2d_oe);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (tx_idle !== 1'b1 || ps2d_oe !== 1'b0) begin
            failures++; $display("FAIL silent_recover got=%0b%0b want=10", tx_idle, ps2d_oe);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_basic();
        test_parity();
        test_no_ack();
        test_reset_mid();
        test_ignore_wr();
        test_random();
        test_silent();
        checks++;
        if (both_cnt !== 0) begin failures++; $display("FAIL done_err_overlap got=%0d want=0", both_cnt); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
